// File: rtl/pic_pkg.sv
// Shared definitions for the CPU-side 8259A acknowledge sequencer and the
// PIC_controlLogic test environment: vector width, default INTA timing and
// the sequencer state encoding.
package pic_pkg;

   // Width of the PIC data bus / interrupt vector.
   localparam int VEC_W = 8;

   // Default INTA timing (in clk cycles) and int_req synchroniser depth.
   localparam int DEF_INTA_LOW_CYCLES = 2;
   localparam int DEF_INTA_GAP_CYCLES = 2;
   localparam int DEF_SYNC_STAGES     = 2;

   // Sequencer states. IDLE is encoded as zero so a cleared register is safe.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARM     = 3'd1,
      P1_LOW  = 3'd2,
      GAP     = 3'd3,
      P2_LOW  = 3'd4,
      PRESENT = 3'd5
   } inta_state_t;

   // Larger of two integers; used to size the shared phase counter.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage flip-flop synchroniser with asynchronous active-high clear.
// Brings an asynchronous level into the clk domain; output is the last stage.
module sync_ff #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [N-1:0] stage_r;

   // Shift the asynchronous input through N flops; reset clears every stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_r <= {N{1'b0}};
      end else begin
         stage_r <= {stage_r[N-2:0], d};
      end
   end

   assign q = stage_r[N-1];

endmodule

// File: rtl/inta_sequencer.sv
// CPU-side initiator of the 8259A INT/INTA handshake (8086 mode).
// Qualifies the synchronised INT line, issues two active-low INTA pulses,
// samples the vector on the last low cycle of pulse 2 and offers it to the
// core over a valid/ready handshake. All outputs come straight from flops.
module inta_sequencer
   import pic_pkg::*;
#(
   parameter int INTA_LOW_CYCLES = DEF_INTA_LOW_CYCLES,
   parameter int INTA_GAP_CYCLES = DEF_INTA_GAP_CYCLES,
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             int_req,
   input  logic             intr_enable,
   input  logic [VEC_W-1:0] pic_data,
   input  logic             pic_data_oe,
   output logic             inta_n,
   output logic [VEC_W-1:0] vector,
   output logic             vector_valid,
   input  logic             vector_ready,
   output logic             spurious,
   output logic             bus_err,
   output logic             busy
);

   // One down-counter serves every timed phase; it holds "cycles left - 1".
   localparam int CNT_MAX = max_int(INTA_LOW_CYCLES, INTA_GAP_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] LOW_LOAD = CNT_W'(INTA_LOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(INTA_GAP_CYCLES - 1);

   logic             int_s;
   logic             cnt_done_s;
   inta_state_t      state_r;
   logic [CNT_W-1:0] cnt_r;

   // int_req is asynchronous to clk; every decision below uses int_s only.
   sync_ff #(
      .N (SYNC_STAGES)
   ) u_int_sync (
      .clk (clk),
      .rst (rst),
      .d   (int_req),
      .q   (int_s)
   );

   assign cnt_done_s = (cnt_r == CNT_ZERO);

   // Sequencer FSM: state, phase counter, INTA line, vector register and flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         cnt_r        <= CNT_ZERO;
         inta_n       <= 1'b1;
         vector       <= {VEC_W{1'b0}};
         vector_valid <= 1'b0;
         spurious     <= 1'b0;
         bus_err      <= 1'b0;
         busy         <= 1'b0;
      end else begin
         // Status pulses last exactly one cycle unless re-asserted below.
         spurious <= 1'b0;
         bus_err  <= 1'b0;

         case (state_r)
            IDLE: begin
               inta_n <= 1'b1;
               if (int_s && intr_enable) begin
                  state_r <= ARM;
                  cnt_r   <= CNT_ZERO;
                  busy    <= 1'b1;
               end else begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end
            end

            // One qualification cycle: INT must still be present.
            ARM: begin
               if (int_s) begin
                  state_r <= P1_LOW;
                  cnt_r   <= LOW_LOAD;
                  inta_n  <= 1'b0;
               end else begin
                  state_r  <= IDLE;
                  cnt_r    <= CNT_ZERO;
                  spurious <= 1'b1;
                  busy     <= 1'b0;
               end
            end

            // The PIC freezes priority on pulse 1, so from here on int_s and
            // intr_enable are ignored and pulse 2 always follows.
            P1_LOW: begin
               if (cnt_done_s) begin
                  state_r <= GAP;
                  cnt_r   <= GAP_LOAD;
                  inta_n  <= 1'b1;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end

            GAP: begin
               if (cnt_done_s) begin
                  state_r <= P2_LOW;
                  cnt_r   <= LOW_LOAD;
                  inta_n  <= 1'b0;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end

            // Capture on the last low cycle; a silent bus leaves vector intact.
            P2_LOW: begin
               if (cnt_done_s) begin
                  inta_n <= 1'b1;
                  cnt_r  <= CNT_ZERO;
                  if (pic_data_oe) begin
                     vector       <= pic_data;
                     vector_valid <= 1'b1;
                     state_r      <= PRESENT;
                  end else begin
                     bus_err <= 1'b1;
                     state_r <= IDLE;
                     busy    <= 1'b0;
                  end
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end

            // Hold the vector until the core takes it; new INTs wait here.
            PRESENT: begin
               if (vector_valid && vector_ready) begin
                  vector_valid <= 1'b0;
                  state_r      <= IDLE;
                  cnt_r        <= CNT_ZERO;
                  busy         <= 1'b0;
               end else begin
                  state_r <= PRESENT;
               end
            end

            default: begin
               state_r      <= IDLE;
               cnt_r        <= CNT_ZERO;
               inta_n       <= 1'b1;
               vector_valid <= 1'b0;
               busy         <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inta_sequencer.sv
// Scoreboard bench for inta_sequencer. A small behavioural PIC answers the
// INTA pulses; stimulus pushes expected events, a monitor pops and compares.
module tb_inta_sequencer;
   import pic_pkg::*;

   localparam int LOWC   = 2;
   localparam int GAPC   = 2;
   localparam int K_VEC  = 0;
   localparam int K_SPUR = 1;
   localparam int K_BERR = 2;

   typedef struct {
      int         kind;
      logic [7:0] vec;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       intr_enable = 1'b0;
   logic       vector_ready = 1'b0;
   logic [7:0] pic_data = 8'h00;
   logic       pic_data_oe = 1'b0;
   logic       int_req;
   logic       inta_n;
   logic [7:0] vector;
   logic       vector_valid;
   logic       spurious;
   logic       bus_err;
   logic       busy;

   // PIC model state
   logic       tb_int = 1'b0;
   int         raise_id = 0;
   int         ack_id = 0;
   int         pic_cnt = 0;
   logic       force_oe_low = 1'b0;
   logic [7:0] pic_vec = 8'h00;

   int   total = 0;
   int   bad = 0;
   int   inta_falls = 0;
   exp_t exp_q[$];

   // INT stays up until the PIC sees the first INTA pulse for that request.
   assign int_req = tb_int && (raise_id != ack_id);

   always #5 clk = ~clk;

   inta_sequencer #(
      .INTA_LOW_CYCLES (LOWC),
      .INTA_GAP_CYCLES (GAPC),
      .SYNC_STAGES     (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .int_req      (int_req),
      .intr_enable  (intr_enable),
      .pic_data     (pic_data),
      .pic_data_oe  (pic_data_oe),
      .inta_n       (inta_n),
      .vector       (vector),
      .vector_valid (vector_valid),
      .vector_ready (vector_ready),
      .spurious     (spurious),
      .bus_err      (bus_err),
      .busy         (busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   task automatic pop_check(input int kind, input logic [7:0] v);
      exp_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL unexpected_event: got kind %0d vec %02h, required no event", kind, v);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || (kind == K_VEC && e.vec !== v)) begin
            bad++;
            $display("FAIL scoreboard_event: got kind %0d vec %02h, required kind %0d vec %02h",
                     kind, v, e.kind, e.vec);
         end
      end
   endtask

   // Behavioural PIC: drop INT on pulse 1, drive the vector during pulse 2.
   always @(inta_n or rst) begin
      if (rst) begin
         pic_cnt     = 0;
         pic_data_oe = 1'b0;
      end else if (inta_n == 1'b0) begin
         pic_cnt++;
         if (pic_cnt == 1) begin
            ack_id = raise_id;
         end else if (!force_oe_low) begin
            pic_data    = pic_vec;
            pic_data_oe = 1'b1;
         end
      end else if (pic_cnt >= 2) begin
         pic_data_oe = 1'b0;
         pic_cnt     = 0;
      end
   end

   // Monitor: pulse shape checks and scoreboard pops, sampled on negedge.
   logic prev_inta = 1'b1;
   logic prev_valid = 1'b0;
   int   low_run = 0;
   int   gap_run = 0;
   int   seq_pulses = 0;
   always @(negedge clk) begin
      if (rst) begin
         prev_inta  = 1'b1;
         prev_valid = 1'b0;
         low_run    = 0;
         gap_run    = 0;
         seq_pulses = 0;
      end else begin
         if (inta_n == 1'b0) begin
            if (prev_inta) begin
               inta_falls++;
               seq_pulses++;
               if (seq_pulses == 2) chk("inta_gap_cycles", 32'(gap_run), 32'(GAPC));
               if (seq_pulses > 2) begin
                  total++;
                  bad++;
                  $display("FAIL inta_pulses_per_seq: got %0d, required 2", seq_pulses);
               end
               low_run = 0;
               gap_run = 0;
            end
            low_run++;
         end else begin
            if (!prev_inta) chk("inta_low_cycles", 32'(low_run), 32'(LOWC));
            if (seq_pulses == 1) gap_run++;
            if (!busy) begin
               seq_pulses = 0;
               gap_run    = 0;
            end
         end
         if (vector_valid && !prev_valid) pop_check(K_VEC, vector);
         if (spurious) pop_check(K_SPUR, 8'h00);
         if (bus_err) pop_check(K_BERR, 8'h00);
         if (spurious && bus_err) begin
            total++;
            bad++;
            $display("FAIL spurious_and_bus_err: got both high, required at most one");
         end
         prev_valid = vector_valid;
         prev_inta  = inta_n;
      end
   end

   task automatic raise_int(input logic [7:0] icw2, input logic [2:0] ir);
      pic_vec = icw2 | {5'b00000, ir};
      raise_id++;
      tb_int = 1'b1;
   endtask

   task automatic wait_valid(input string nm);
      int n = 0;
      while (vector_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_valid_reached"}, 32'(vector_valid), 32'd1);
   endtask

   task automatic wait_inta_low(input string nm);
      int n = 0;
      while (inta_n !== 1'b0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_inta_low_reached"}, 32'(inta_n), 32'd0);
   endtask

   task automatic accept(input string nm);
      vector_ready = 1'b1;
      @(negedge clk);
      vector_ready = 1'b0;
      chk({nm, "_valid_cleared"}, 32'(vector_valid), 32'd0);
      chk({nm, "_busy_after_accept"}, 32'(busy), 32'd0);
   endtask

   logic [9:0] tr_inta;
   logic [9:0] tr_val;
   logic [9:0] exp_inta;
   logic [9:0] exp_val;
   int         f0;

   initial begin
      // Reset state
      #1 rst = 1'b1;
      #1;
      chk("rst_inta_n", 32'(inta_n), 32'd1);
      chk("rst_vector", 32'(vector), 32'h00);
      chk("rst_valid", 32'(vector_valid), 32'd0);
      chk("rst_spurious", 32'(spurious), 32'd0);
      chk("rst_bus_err", 32'(bus_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      intr_enable = 1'b1;
      repeat (2) @(negedge clk);

      // Basic: ICW2=A8, IR1 -> A9, cycle-exact pulse train
      exp_q.push_back('{K_VEC, 8'hA9});
      f0 = inta_falls;
      raise_int(8'hA8, 3'd1);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         tr_inta[c-1] = inta_n;
         tr_val[c-1]  = vector_valid;
      end
      exp_inta = 10'b1001100111;
      exp_val  = 10'b1000000000;
      chk("t1_inta_trace", 32'(tr_inta), 32'(exp_inta));
      chk("t1_valid_trace", 32'(tr_val), 32'(exp_val));
      chk("t1_vector", 32'(vector), 32'hA9);
      accept("t1");
      chk("t1_pulse_count", 32'(inta_falls - f0), 32'd2);
      repeat (3) @(negedge clk);

      // Cascade: master ICW3=04, slave ICW2=A8/ICW3=02, slave IR1 -> A9.
      // intr_enable is dropped mid-sequence and must not abort it.
      exp_q.push_back('{K_VEC, 8'hA9});
      f0 = inta_falls;
      raise_int(8'hA8, 3'd1);
      wait_inta_low("t2");
      intr_enable = 1'b0;
      wait_valid("t2");
      intr_enable = 1'b1;
      accept("t2");
      chk("t2_pulse_count", 32'(inta_falls - f0), 32'd2);
      repeat (3) @(negedge clk);

      // Short INT withdrawn before ARM completes -> spurious, no INTA
      exp_q.push_back('{K_SPUR, 8'h00});
      f0 = inta_falls;
      raise_id++;
      tb_int = 1'b1;
      @(negedge clk);
      tb_int = 1'b0;
      repeat (8) @(negedge clk);
      chk("t3_pulse_count", 32'(inta_falls - f0), 32'd0);
      chk("t3_valid", 32'(vector_valid), 32'd0);
      chk("t3_busy", 32'(busy), 32'd0);

      // PIC silent during pulse 2 -> bus_err, vector keeps A9
      exp_q.push_back('{K_BERR, 8'h00});
      force_oe_low = 1'b1;
      f0 = inta_falls;
      raise_int(8'h40, 3'd3);
      repeat (14) @(negedge clk);
      force_oe_low = 1'b0;
      chk("t4_vector_kept", 32'(vector), 32'hA9);
      chk("t4_valid", 32'(vector_valid), 32'd0);
      chk("t4_busy", 32'(busy), 32'd0);
      chk("t4_pulse_count", 32'(inta_falls - f0), 32'd2);

      // Core stalls 20 cycles while INT is re-raised
      exp_q.push_back('{K_VEC, 8'h5C});
      f0 = inta_falls;
      raise_int(8'h58, 3'd4);
      wait_valid("t5a");
      exp_q.push_back('{K_VEC, 8'h5D});
      raise_int(8'h58, 3'd5);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("t5_hold_valid", 32'(vector_valid), 32'd1);
         chk("t5_hold_vector", 32'(vector), 32'h5C);
      end
      chk("t5_no_third_pulse", 32'(inta_falls - f0), 32'd2);
      accept("t5a");
      wait_valid("t5b");
      chk("t5_second_vector", 32'(vector), 32'h5D);
      accept("t5b");
      chk("t5_pulse_count", 32'(inta_falls - f0), 32'd4);
      repeat (3) @(negedge clk);

      // Reset during P1_LOW releases inta_n asynchronously
      raise_int(8'h70, 3'd5);
      wait_inta_low("t6");
      rst = 1'b1;
      #1;
      chk("t6_async_inta_n", 32'(inta_n), 32'd1);
      chk("t6_vector", 32'(vector), 32'h00);
      chk("t6_valid", 32'(vector_valid), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      exp_q.push_back('{K_VEC, 8'h75});
      f0 = inta_falls;
      raise_int(8'h70, 3'd5);
      wait_valid("t6");
      accept("t6");
      chk("t6_pulse_count", 32'(inta_falls - f0), 32'd2);

      // Interrupts disabled: INT pending but ignored until enabled
      intr_enable = 1'b0;
      f0 = inta_falls;
      raise_int(8'h20, 3'd1);
      repeat (10) @(negedge clk);
      chk("t7_disabled_busy", 32'(busy), 32'd0);
      chk("t7_disabled_pulses", 32'(inta_falls - f0), 32'd0);
      exp_q.push_back('{K_VEC, 8'h21});
      intr_enable = 1'b1;
      wait_valid("t7");
      accept("t7");
      chk("t7_pulse_count", 32'(inta_falls - f0), 32'd2);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
